// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: stereo PCM to Philips I2S (BCLK/LRCLK/SDATA) serializer.
// Timing comes only from bclk_en; a one-entry buffer takes samples by valid/ready.
// Ports: clk, rst (sync, active-high), bclk_en, s_valid/s_ready/s_left/s_right,
//        i2s_bclk, i2s_lrclk, i2s_sdata, underrun (one-cycle pulse).
// Option: define I2S_REPEAT_ON_UNDERRUN_EN to replay the last pair on underrun.
module i2s_tx_serializer #(
  parameter int DATA_W = 24,
  parameter int SLOT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bclk_en,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              i2s_bclk,
  output logic              i2s_lrclk,
  output logic              i2s_sdata,
  output logic              underrun
);

  localparam int FRAME = 2 * SLOT_W;
  localparam int PW    = $clog2(FRAME);

  localparam logic [PW-1:0] POS_MAX = PW'(FRAME - 1);
  localparam logic [PW-1:0] POS_R0  = PW'(SLOT_W);
  localparam logic [PW-1:0] L_FIRST = PW'(1);
  localparam logic [PW-1:0] L_LAST  = PW'(DATA_W);
  localparam logic [PW-1:0] R_FIRST = PW'(SLOT_W + 1);
  localparam logic [PW-1:0] R_LAST  = PW'(SLOT_W + DATA_W);

  logic              bclk_q;
  logic              lrclk_q;
  logic              sdata_q;
  logic              urun_q;
  logic              full_q;
  logic [PW-1:0]     pos_q;
  logic [PW-1:0]     pos_d;
  logic [DATA_W-1:0] hl_q;
  logic [DATA_W-1:0] hr_q;
  logic [DATA_W-1:0] sl_q;
  logic [DATA_W-1:0] sr_q;
  logic [DATA_W-1:0] ul;
  logic [DATA_W-1:0] ur;

  logic fall;
  logic start;
  logic accept;
  logic in_left;
  logic in_right;

  // A fall event is a toggle while BCLK is high.
  assign fall   = bclk_en & bclk_q;
  assign pos_d  = (pos_q == POS_MAX) ? '0 : pos_q + PW'(1);
  assign start  = fall & (pos_q == POS_MAX);
  assign accept = s_valid & ~full_q;

  assign in_left  = (pos_d >= L_FIRST) && (pos_d <= L_LAST);
  assign in_right = (pos_d >= R_FIRST) && (pos_d <= R_LAST);

  assign s_ready   = ~full_q;
  assign i2s_bclk  = bclk_q;
  assign i2s_lrclk = lrclk_q;
  assign i2s_sdata = sdata_q;
  assign underrun  = urun_q;

`ifdef I2S_REPEAT_ON_UNDERRUN_EN
  logic [DATA_W-1:0] last_l_q;
  logic [DATA_W-1:0] last_r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_l_q <= '0;
      last_r_q <= '0;
    end else if (start && full_q) begin
      last_l_q <= hl_q;
      last_r_q <= hr_q;
    end
  end

  assign ul = last_l_q;
  assign ur = last_r_q;
`else
  assign ul = '0;
  assign ur = '0;
`endif

  // Accept needs full_q=0 and a load needs full_q=1, so the
  // two writes to full_q below are mutually exclusive.
  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_q  <= 1'b0;
      lrclk_q <= 1'b0;
      sdata_q <= 1'b0;
      urun_q  <= 1'b0;
      full_q  <= 1'b0;
      pos_q   <= POS_MAX;
      hl_q    <= '0;
      hr_q    <= '0;
      sl_q    <= '0;
      sr_q    <= '0;
    end else begin
      urun_q <= 1'b0;
      if (bclk_en) begin
        bclk_q <= ~bclk_q;
      end
      if (accept) begin
        hl_q   <= s_left;
        hr_q   <= s_right;
        full_q <= 1'b1;
      end
      if (fall) begin
        pos_q   <= pos_d;
        lrclk_q <= (pos_d >= POS_R0);
        sdata_q <= 1'b0;
        if (start) begin
          // Position 0 is the one-bit delay slot.
          if (full_q) begin
            sl_q   <= hl_q;
            sr_q   <= hr_q;
            full_q <= 1'b0;
          end else begin
            sl_q   <= ul;
            sr_q   <= ur;
            urun_q <= 1'b1;
          end
        end else if (in_left) begin
          sdata_q <= sl_q[DATA_W-1];
          sl_q    <= sl_q << 1;
        end else if (in_right) begin
          sdata_q <= sr_q[DATA_W-1];
          sr_q    <= sr_q << 1;
        end
      end
    end
  end

endmodule
